// File: rtl/i2c_bus_conditioner.sv
// ---------------------------------------------------------------------------
// i2c_bus_conditioner
// Input conditioning ahead of the I2C slave. Each raw pad line passes through
// a plain flop synchroniser and then a stability filter that suppresses spikes.
// The filtered lines drive START/STOP strobes and a bus-busy flag that has an
// idle timeout.
//
// Ports
//   i_clk      system clock (single domain)
//   i_rst      synchronous reset, active-high
//   i_scl_raw  asynchronous SCL from pad
//   i_sda_raw  asynchronous SDA from pad
//   o_scl      filtered SCL
//   o_sda      filtered SDA
//   o_start    one-cycle START strobe
//   o_stop     one-cycle STOP strobe
//   o_busy     bus-busy flag
//   o_glitch   one-cycle strobe: a spike was rejected on either line
// ---------------------------------------------------------------------------
module i2c_bus_conditioner #(
  parameter int SYNC_STAGES   = 2,
  parameter int FILT_CLKS     = 4,
  parameter int WIDTH_FILT    = 3,
  parameter int BUSY_TO_CLKS  = 800,
  parameter int WIDTH_BUSY_TO = 10
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_scl_raw,
  input  logic i_sda_raw,
  output logic o_scl,
  output logic o_sda,
  output logic o_start,
  output logic o_stop,
  output logic o_busy,
  output logic o_glitch
);

  localparam logic [WIDTH_FILT-1:0]    FILT_LAST = WIDTH_FILT'(FILT_CLKS - 1);
  localparam logic [WIDTH_BUSY_TO-1:0] BUSY_LAST = WIDTH_BUSY_TO'(BUSY_TO_CLKS - 1);

  typedef struct packed {
    logic                  f;
    logic [WIDTH_FILT-1:0] cnt;
  } filt_t;

  logic [SYNC_STAGES-1:0] scl_sync;
  logic [SYNC_STAGES-1:0] sda_sync;
  logic                   s_scl;
  logic                   s_sda;
  filt_t                  scl_q;
  filt_t                  sda_q;
  filt_t                  scl_d;
  filt_t                  sda_d;
  logic                   scl_glitch;
  logic                   sda_glitch;
  logic                   p_scl;
  logic                   p_sda;
  logic                   start_c;
  logic                   stop_c;
  logic [WIDTH_BUSY_TO-1:0] busy_cnt;

  // One filter step: the output only follows the synchronised sample after
  // FILT_CLKS consecutive disagreeing samples; an early return to agreement
  // discards the partial count.
  function automatic filt_t filt_step(input logic s, input filt_t q);
    filt_t n;
    n = q;
    if (s != q.f) begin
      if (q.cnt == FILT_LAST) begin
        n.f   = s;
        n.cnt = '0;
      end else begin
        n.cnt = q.cnt + 1'b1;
      end
    end else if (q.cnt != '0) begin
      n.cnt = '0;
    end
    return n;
  endfunction

  assign s_scl = scl_sync[SYNC_STAGES-1];
  assign s_sda = sda_sync[SYNC_STAGES-1];
  assign o_scl = scl_q.f;
  assign o_sda = sda_q.f;

  always_comb begin
    scl_d      = filt_step(s_scl, scl_q);
    sda_d      = filt_step(s_sda, sda_q);
    scl_glitch = (s_scl == scl_q.f) && (scl_q.cnt != '0);
    sda_glitch = (s_sda == sda_q.f) && (sda_q.cnt != '0);
    // Requiring SCL high both before and after rejects a simultaneous SCL/SDA move.
    start_c    = p_sda & ~sda_q.f & p_scl & scl_q.f;
    stop_c     = ~p_sda & sda_q.f & p_scl & scl_q.f;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_q    <= '{f: 1'b1, cnt: '0};
      sda_q    <= '{f: 1'b1, cnt: '0};
      p_scl    <= 1'b1;
      p_sda    <= 1'b1;
      o_start  <= 1'b0;
      o_stop   <= 1'b0;
      o_glitch <= 1'b0;
      o_busy   <= 1'b0;
      busy_cnt <= '0;
    end else begin
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], i_scl_raw};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], i_sda_raw};
      scl_q    <= scl_d;
      sda_q    <= sda_d;
      p_scl    <= scl_q.f;
      p_sda    <= sda_q.f;
      o_start  <= start_c;
      o_stop   <= stop_c;
      o_glitch <= scl_glitch | sda_glitch;

      // Idle timer: consecutive both-high cycles, saturating.
      if (start_c || !scl_q.f || !sda_q.f) begin
        busy_cnt <= '0;
      end else if (busy_cnt != BUSY_LAST) begin
        busy_cnt <= busy_cnt + 1'b1;
      end

      if (start_c) begin
        o_busy <= 1'b1;
      end else if (stop_c) begin
        o_busy <= 1'b0;
      end else if (o_busy && (busy_cnt == BUSY_LAST)) begin
        o_busy <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_i2c_bus_conditioner.sv
// ---------------------------------------------------------------------------
// tb_i2c_bus_conditioner
// Scoreboard bench: each stimulus step pushes the output events it should
// cause (kind + clock edge number) into a queue; a monitor on the falling
// clock edge turns every observed output change/strobe into an event and
// matches it against the oldest queued expectation of the same kind.
// ---------------------------------------------------------------------------
module tb_i2c_bus_conditioner;

  localparam int SYNC_STAGES  = 2;
  localparam int FILT_CLKS    = 4;
  localparam int BUSY_TO_CLKS = 800;
  // Raw change driven before edge m+1 shows on a filtered output after edge m+LAT.
  localparam int LAT          = SYNC_STAGES + FILT_CLKS;

  localparam int EV_SDA_FALL  = 1;
  localparam int EV_SDA_RISE  = 2;
  localparam int EV_SCL_FALL  = 3;
  localparam int EV_SCL_RISE  = 4;
  localparam int EV_START     = 5;
  localparam int EV_STOP      = 6;
  localparam int EV_GLITCH    = 7;
  localparam int EV_BUSY_RISE = 8;
  localparam int EV_BUSY_FALL = 9;

  typedef struct {
    int kind;
    int cyc;
  } ev_t;

  logic i_clk = 1'b0;
  logic i_rst;
  logic i_scl_raw;
  logic i_sda_raw;
  logic o_scl;
  logic o_sda;
  logic o_start;
  logic o_stop;
  logic o_busy;
  logic o_glitch;

  int   edge_n = 0;
  int   n_cmp  = 0;
  int   n_err  = 0;
  logic mon_en = 1'b0;
  logic prev_scl;
  logic prev_sda;
  logic prev_busy;
  ev_t  exp_q[$];
  int   m;

  i2c_bus_conditioner #(
    .SYNC_STAGES  (SYNC_STAGES),
    .FILT_CLKS    (FILT_CLKS),
    .WIDTH_FILT   (3),
    .BUSY_TO_CLKS (BUSY_TO_CLKS),
    .WIDTH_BUSY_TO(10)
  ) dut (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_scl_raw(i_scl_raw),
    .i_sda_raw(i_sda_raw),
    .o_scl    (o_scl),
    .o_sda    (o_sda),
    .o_start  (o_start),
    .o_stop   (o_stop),
    .o_busy   (o_busy),
    .o_glitch (o_glitch)
  );

  always #5 i_clk = ~i_clk;

  always @(posedge i_clk) edge_n++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (edge %0d)", tag, got, exp, edge_n);
    end
  endtask

  function automatic string ev_name(input int kind);
    case (kind)
      EV_SDA_FALL:  return "sda_fall";
      EV_SDA_RISE:  return "sda_rise";
      EV_SCL_FALL:  return "scl_fall";
      EV_SCL_RISE:  return "scl_rise";
      EV_START:     return "start";
      EV_STOP:      return "stop";
      EV_GLITCH:    return "glitch";
      EV_BUSY_RISE: return "busy_rise";
      EV_BUSY_FALL: return "busy_fall";
      default:      return "unknown";
    endcase
  endfunction

  task automatic push(input int kind, input int cyc);
    ev_t e;
    e.kind = kind;
    e.cyc  = cyc;
    exp_q.push_back(e);
  endtask

  task automatic observe(input int kind);
    int idx;
    idx = -1;
    foreach (exp_q[i]) begin
      if (idx < 0 && exp_q[i].kind == kind) idx = i;
    end
    if (idx < 0) begin
      check({"unexpected_", ev_name(kind)}, 32'(kind), 32'd0);
    end else begin
      check({ev_name(kind), "_edge"}, 32'(edge_n), 32'(exp_q[idx].cyc));
      exp_q.delete(idx);
    end
  endtask

  // Strobes are reported once per high cycle, so a stretched pulse shows up
  // as an unexpected second event.
  always @(negedge i_clk) begin
    if (mon_en) begin
      if (o_sda !== prev_sda) observe(o_sda ? EV_SDA_RISE : EV_SDA_FALL);
      if (o_scl !== prev_scl) observe(o_scl ? EV_SCL_RISE : EV_SCL_FALL);
      if (o_start !== 1'b0)   observe(EV_START);
      if (o_stop !== 1'b0)    observe(EV_STOP);
      if (o_glitch !== 1'b0)  observe(EV_GLITCH);
      if (o_busy !== prev_busy) observe(o_busy ? EV_BUSY_RISE : EV_BUSY_FALL);
      prev_sda  = o_sda;
      prev_scl  = o_scl;
      prev_busy = o_busy;
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge i_clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_scl"},    32'(o_scl),    32'd1);
    check({tag, "_sda"},    32'(o_sda),    32'd1);
    check({tag, "_start"},  32'(o_start),  32'd0);
    check({tag, "_stop"},   32'(o_stop),   32'd0);
    check({tag, "_busy"},   32'(o_busy),   32'd0);
    check({tag, "_glitch"}, 32'(o_glitch), 32'd0);
  endtask

  initial begin
    i_rst     = 1'b1;
    i_scl_raw = 1'b1;
    i_sda_raw = 1'b1;
    step(3);
    check_reset_outputs("reset");
    i_rst     = 1'b0;
    prev_scl  = o_scl;
    prev_sda  = o_sda;
    prev_busy = o_busy;
    mon_en    = 1'b1;

    // 1: START by SDA falling while SCL high, then SCL falls.
    step(10);
    i_sda_raw = 1'b0; m = edge_n;
    push(EV_SDA_FALL, m + LAT);
    push(EV_START, m + LAT + 1);
    push(EV_BUSY_RISE, m + LAT + 1);
    step(20);
    i_scl_raw = 1'b0; m = edge_n;
    push(EV_SCL_FALL, m + LAT);

    // 3: SCL high, then SDA rises -> STOP, busy cleared.
    step(15);
    i_scl_raw = 1'b1; m = edge_n;
    push(EV_SCL_RISE, m + LAT);
    step(15);
    i_sda_raw = 1'b1; m = edge_n;
    push(EV_SDA_RISE, m + LAT);
    push(EV_STOP, m + LAT + 1);
    push(EV_BUSY_FALL, m + LAT + 1);

    // 2a: 3-sample SDA spike is rejected.
    step(15);
    i_sda_raw = 1'b0; m = edge_n;
    step(FILT_CLKS - 1);
    i_sda_raw = 1'b1;
    push(EV_GLITCH, m + SYNC_STAGES + 1 + (FILT_CLKS - 1));

    // 2b: 4-sample SDA pulse passes -> START then STOP.
    step(15);
    i_sda_raw = 1'b0; m = edge_n;
    step(FILT_CLKS);
    i_sda_raw = 1'b1;
    push(EV_SDA_FALL, m + LAT);
    push(EV_START, m + LAT + 1);
    push(EV_BUSY_RISE, m + LAT + 1);
    push(EV_SDA_RISE, m + LAT + FILT_CLKS);
    push(EV_STOP, m + LAT + FILT_CLKS + 1);
    push(EV_BUSY_FALL, m + LAT + FILT_CLKS + 1);

    // 4: both lines fall, then rise, on the same edge -> no strobes.
    step(15);
    i_scl_raw = 1'b0; i_sda_raw = 1'b0; m = edge_n;
    push(EV_SCL_FALL, m + LAT);
    push(EV_SDA_FALL, m + LAT);
    step(15);
    i_scl_raw = 1'b1; i_sda_raw = 1'b1; m = edge_n;
    push(EV_SCL_RISE, m + LAT);
    push(EV_SDA_RISE, m + LAT);

    // 5: START, repeated START while busy, then idle timeout without STOP.
    step(15);
    i_sda_raw = 1'b0; m = edge_n;
    push(EV_SDA_FALL, m + LAT);
    push(EV_START, m + LAT + 1);
    push(EV_BUSY_RISE, m + LAT + 1);
    step(15);
    i_scl_raw = 1'b0; m = edge_n;
    push(EV_SCL_FALL, m + LAT);
    step(15);
    i_sda_raw = 1'b1; m = edge_n;
    push(EV_SDA_RISE, m + LAT);
    step(15);
    i_scl_raw = 1'b1; m = edge_n;
    push(EV_SCL_RISE, m + LAT);
    step(15);
    i_sda_raw = 1'b0; m = edge_n;
    push(EV_SDA_FALL, m + LAT);
    push(EV_START, m + LAT + 1);
    step(15);
    i_scl_raw = 1'b0; m = edge_n;
    push(EV_SCL_FALL, m + LAT);
    step(15);
    i_sda_raw = 1'b1; m = edge_n;
    push(EV_SDA_RISE, m + LAT);
    step(15);
    i_scl_raw = 1'b1; m = edge_n;
    push(EV_SCL_RISE, m + LAT);
    push(EV_BUSY_FALL, m + LAT + BUSY_TO_CLKS);
    step(LAT + BUSY_TO_CLKS + 20);

    // 6: reset while SDA is two samples into the filter.
    i_sda_raw = 1'b0;
    step(SYNC_STAGES + 2);
    i_rst = 1'b1;
    step(1);
    i_rst = 1'b0;
    check_reset_outputs("midfilt_reset");
    m = edge_n;
    push(EV_SDA_FALL, m + LAT);
    push(EV_START, m + LAT + 1);
    push(EV_BUSY_RISE, m + LAT + 1);
    step(20);

    foreach (exp_q[i]) $display("pending: %s at edge %0d", ev_name(exp_q[i].kind), exp_q[i].cyc);
    check("pending_events", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/i2c_bus_conditioner.md
Name: i2c_bus_conditioner

Overview:
Input conditioning stage that sits directly upstream of the single-byte I2C slave.
- Synchronises raw SCL/SDA pad inputs into i_clk and suppresses spikes with per-line stability counters.
- Presents clean o_scl/o_sda for the slave's i_scl/i_sda.
- Also emits registered START/STOP strobes and a bus-busy flag for status and debug logic.

Parameters:
SYNC_STAGES, 2, synchroniser depth per line; legal 2..4.
FILT_CLKS, 4, consecutive identical synchronised samples required before a filtered output changes; legal 1..7 (1 = no filtering).
WIDTH_FILT, 3, filter counter width; must hold FILT_CLKS.
BUSY_TO_CLKS, 800, consecutive cycles with both filtered lines high that force o_busy low.
WIDTH_BUSY_TO, 10, busy timeout counter width; must hold BUSY_TO_CLKS.

Ports:
i_clk  input  1  system clock; single clock domain.
i_rst  input  1  synchronous reset, active-high.
i_scl_raw  input  1  asynchronous SCL from pad.
i_sda_raw  input  1  asynchronous SDA from pad.
o_scl  output  1  filtered SCL.
o_sda  output  1  filtered SDA.
o_start  output  1  one-cycle START strobe.
o_stop  output  1  one-cycle STOP strobe.
o_busy  output  1  bus-busy flag.
o_glitch  output  1  one-cycle strobe: a spike was rejected on either line.

Behaviour:
- Reset (i_rst high at a rising i_clk edge):
  - all synchroniser flops = 1; o_scl = o_sda = 1; filter counters = 0.
  - o_start = o_stop = o_glitch = o_busy = 0; busy timeout counter = 0.
  - Reset mid-filter discards any partial count.
- Synchroniser: plain SYNC_STAGES-deep flop chain per line; no logic between stages.
- Filter, per line, each cycle compares the synchronised sample s with the filtered output f:
  - s != f and cnt == FILT_CLKS-1: f <= s, cnt <= 0.
  - s != f otherwise: cnt <= cnt+1.
  - s == f and cnt != 0: cnt <= 0, glitch pulse for that line.
  - s == f and cnt == 0: hold.
- o_glitch = registered OR of both lines' glitch pulses.
- Latency: a clean raw edge set up before clock edge k appears on o_scl/o_sda after edge k+SYNC_STAGES+FILT_CLKS-1 (6 cycles at defaults). Any level held for fewer than FILT_CLKS synchronised samples never reaches the output.
- Edge detection uses filtered lines and their one-cycle-delayed copies p_scl/p_sda:
  - start_c = p_sda & ~o_sda & p_scl & o_scl.
  - stop_c = ~p_sda & o_sda & p_scl & o_scl.
  - o_start and o_stop are registered from these, asserting one cycle after the filtered SDA transition, for exactly one cycle.
- Simultaneous filtered SCL and SDA change in the same cycle: the p_scl & o_scl term fails, so neither strobe asserts.
- Busy flag:
  - Timeout counter counts consecutive cycles with o_scl = o_sda = 1. It clears whenever either line is low, and also on start_c.
  - Priority: start_c sets o_busy (highest); else stop_c clears it; else the counter reaching BUSY_TO_CLKS-1 with o_busy high clears it.
  - The counter saturates at BUSY_TO_CLKS-1, never wraps.
- A repeated START while busy keeps o_busy = 1 and still pulses o_start.
- No combinational path from any input to any output.

Test Plan:
1. Reset, both raw lines high; drop i_sda_raw at cycle 10, then i_scl_raw at cycle 30 -> o_sda falls 6 cycles after its raw edge; o_start = 1 for exactly one cycle, one cycle after o_sda falls; o_busy = 1 from the next cycle.
2. With SCL high, pulse i_sda_raw low for 3 cycles (FILT_CLKS = 4) -> o_sda stays 1; o_glitch = 1 for one cycle; o_start never asserts. Repeat with a 4-cycle pulse -> o_sda low for 4 cycles; START then STOP strobes.
3. Busy bus, SCL high, raise i_sda_raw -> o_stop = 1 for one cycle; o_busy = 0 the following cycle.
4. Drive i_scl_raw and i_sda_raw high-to-low on the same clock edge -> filtered lines change in the same cycle; o_start = o_stop = 0.
5. Set busy via START, then hold both lines high with no STOP -> o_busy drops after 800 cycles; no o_stop strobe.
6. Assert i_rst for one cycle while an SDA transition is 2 samples into the filter -> all outputs at reset values next cycle. The held-low line then needs a full 2+4 cycles before o_sda falls.
